// File: rtl/vec_proc_pkg.sv
// Purpose : shared types and constants for the vector instruction path.
// Latency : n/a (package only).
// Backpressure: n/a. Contents: opcode values, instruction field layout, sequencer state encoding, opcode masking helper.
package vec_proc_pkg;

  localparam int INSTR_W  = 13;
  localparam int OPC_MSB  = 12;
  localparam int OPC_LSB  = 11;
  localparam int REG_MSB  = 10;
  localparam int REG_LSB  = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 0;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // ADD/MUL operate register-to-register on fixed operands, so their reg and
  // addr fields carry no meaning downstream and are zeroed before issue.
  function automatic instr_t mask_instr(input instr_t i);
    instr_t r;
    r = i;
    if (i[OPC_MSB]) begin
      r[REG_MSB:ADDR_LSB] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vector_instr_sequencer_if.sv
// Purpose : host/processor-side bundle of the vector instruction sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; the sequencer paces issue by fixed hold counts. master = host + processor side, slave = sequencer.
interface vector_instr_sequencer_if
  import vec_proc_pkg::*;
#(
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  instr_t            prog_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              abort;
  instr_t            instruction;
  logic              instr_valid;
  logic [ADDR_W:0]   pc;
  logic              busy;
  logic              done;

  modport master (
    output prog_we, prog_addr, prog_data, start, len, abort,
    input  instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, len, abort,
    output instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/vec_prog_buffer.sv
// Purpose : DEPTH x 13 program store; synchronous write, combinational read.
// Latency : write visible on the read port the cycle after the write edge; read is 0 cycles.
// Backpressure: none; caller gates we. Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module vec_prog_buffer
  import vec_proc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  instr_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output instr_t            rdata
);

  // Program contents deliberately survive reset.
  instr_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vector_instr_sequencer.sv
// Purpose : issues a host-loaded vector program one instruction at a time, holding each for an opcode-dependent count.
// Latency : first instruction appears the cycle after start; done pulses the cycle after the last hold cycle.
// Backpressure: none; fixed hold counts pace the processor. Ports: clk, rst (sync, active-low), bus (slave modport).
module vector_instr_sequencer
  import vec_proc_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int HOLD_W       = 8,
  parameter int LOAD_CYCLES  = 10,
  parameter int STORE_CYCLES = 10,
  parameter int ADD_CYCLES   = 10,
  parameter int MUL_CYCLES   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  vector_instr_sequencer_if.slave  bus
);

  // A hold count of zero would make an instruction invisible; treat it as 1.
  localparam int LOAD_H  = (LOAD_CYCLES  == 0) ? 1 : LOAD_CYCLES;
  localparam int STORE_H = (STORE_CYCLES == 0) ? 1 : STORE_CYCLES;
  localparam int ADD_H   = (ADD_CYCLES   == 0) ? 1 : ADD_CYCLES;
  localparam int MUL_H   = (MUL_CYCLES   == 0) ? 1 : MUL_CYCLES;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  // The counter is loaded with hold-1 because the issue cycle itself counts.
  function automatic logic [HOLD_W-1:0] hold_m1(input logic [1:0] op);
    logic [HOLD_W-1:0] h;
    case (op)
      OP_LOAD:  h = HOLD_W'(LOAD_H  - 1);
      OP_STORE: h = HOLD_W'(STORE_H - 1);
      OP_ADD:   h = HOLD_W'(ADD_H   - 1);
      default:  h = HOLD_W'(MUL_H   - 1);
    endcase
    return h;
  endfunction

  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   pc_q, pc_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] rd_addr;
  instr_t            rd_data;
  instr_t            rd_masked;
  logic              buf_we;
  logic              start_go;
  logic              run_last;

  logic              busy_o;
  logic              vld_o;

  assign len_eff   = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
  // In IDLE the next issue is always entry 0; in RUN it is entry pc.
  assign rd_addr   = (state_q == IDLE) ? '0 : pc_q[ADDR_W-1:0];
  assign rd_masked = mask_instr(rd_data);
  assign buf_we    = bus.prog_we && (state_q == IDLE);
  assign start_go  = (state_q == IDLE) && bus.start && !bus.abort;
  assign run_last  = (cnt_q == '0) && (pc_q >= len_eff);

  vec_prog_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State register (plus datapath flops).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_go && (len_eff != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort || run_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: issue, hold countdown, program counter, done pulse.
  always_comb begin
    instr_d = instr_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          if (len_eff == '0) begin
            done_d = 1'b1;
          end else begin
            instr_d = rd_masked;
            cnt_d   = hold_m1(rd_data[OPC_MSB:OPC_LSB]);
            pc_d    = (ADDR_W+1)'(1);
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          // Cancel without a done pulse; instruction keeps its last value.
          cnt_d = '0;
          pc_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pc_q < len_eff) begin
          instr_d = rd_masked;
          cnt_d   = hold_m1(rd_data[OPC_MSB:OPC_LSB]);
          pc_d    = pc_q + 1'b1;
        end else begin
          pc_d   = '0;
          done_d = 1'b1;
        end
      end
      default: begin
        pc_d = '0;
      end
    endcase
  end

  // Output logic: valid and busy coincide exactly with the RUN state.
  always_comb begin
    busy_o = (state_q == RUN);
    vld_o  = (state_q == RUN);
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = vld_o;
  assign bus.busy        = busy_o;
  assign bus.pc          = pc_q;
  assign bus.done        = done_q;

endmodule
